// File: rtl/atmega_eep_pkg.sv
// rtl/atmega_eep_pkg.sv - shared constants, state encodings and commit helper for the EEPROM controller
package atmega_eep_pkg;

   localparam int EECR_EERE  = 0;
   localparam int EECR_EEPE  = 1;
   localparam int EECR_EEMPE = 2;
   localparam int EECR_EERIE = 3;

   localparam logic [1:0] EEPM_ERASE_WRITE = 2'b00;
   localparam logic [1:0] EEPM_ERASE       = 2'b01;
   localparam logic [1:0] EEPM_WRITE       = 2'b10;
   localparam logic [1:0] EEPM_NONE        = 2'b11;

   localparam logic [7:0] ERASED_BYTE = 8'hFF;

   typedef logic [2:0] eep_state_t;
   localparam eep_state_t S_IDLE   = 3'd0;
   localparam eep_state_t S_RD     = 3'd1;
   localparam eep_state_t S_PRG_RD = 3'd2;
   localparam eep_state_t S_PRG    = 3'd3;
   localparam eep_state_t S_EXT    = 3'd4;

   // Write-only mode can only clear bits, hence the AND with the old byte.
   function automatic logic [7:0] commit_byte(input logic [1:0] eepm,
                                              input logic [7:0] old_byte,
                                              input logic [7:0] new_byte);
      case (eepm)
         EEPM_ERASE: commit_byte = ERASED_BYTE;
         EEPM_WRITE: commit_byte = old_byte & new_byte;
         default:    commit_byte = new_byte;
      endcase
   endfunction

endpackage

// File: rtl/atmega_eep_ram.sv
// rtl/atmega_eep_ram.sv - single-port synchronous-read byte array for the EEPROM controller
// Bytes are stored inverted so a zero-initialised array reads back as erased (8'hFF).
module atmega_eep_ram #(
   parameter string PLATFORM = "XILINX",
   parameter int    DEPTH    = 1024
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [7:0]               i_wdata,
   output logic [7:0]               o_rdata
);

   logic [7:0] r_q;

   generate
      if (PLATFORM == "XILINX") begin : g_xilinx
         (* ram_style = "block" *) logic [7:0] r_mem [DEPTH];
         always_ff @(posedge i_clk) begin
            if (i_we) r_mem[i_addr] <= ~i_wdata;
            if (i_re) r_q <= ~r_mem[i_addr];
         end
      end else begin : g_generic
         logic [7:0] r_mem [DEPTH];
         always_ff @(posedge i_clk) begin
            if (i_we) r_mem[i_addr] <= ~i_wdata;
            if (i_re) r_q <= ~r_mem[i_addr];
         end
      end
   endgenerate

   assign o_rdata = r_q;

endmodule

// File: rtl/atmega_eep_ctrl.sv
// rtl/atmega_eep_ctrl.sv - ATmega-compatible EEPROM controller with arbitrated external port
// EEP_PROG_TIMING_EN selects the full WRITE_CYCLES programming delay; otherwise PRG lasts one clock.
module atmega_eep_ctrl
   import atmega_eep_pkg::*;
#(
   parameter string                        PLATFORM          = "XILINX",
   parameter int                           BUS_ADDR_DATA_LEN = 8,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EEARH_ADDR        = 'h20,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EEARL_ADDR        = 'h21,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EEDR_ADDR         = 'h22,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EECR_ADDR         = 'h23,
   parameter int                           EEP_SIZE          = 1024,
   parameter int                           WRITE_CYCLES      = 16,
   parameter int                           EEMPE_WINDOW      = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
   input  logic                         wr_i,
   input  logic                         rd_i,
   input  logic [7:0]                   bus_i,
   output logic [7:0]                   bus_o,
   output logic                         int_o,
   input  logic [15:0]                  ext_addr_i,
   input  logic [7:0]                   ext_data_i,
   input  logic                         ext_wr_i,
   input  logic                         ext_rd_i,
   output logic [7:0]                   ext_data_o,
   output logic                         ext_ack_o,
   output logic                         content_modified_o
);

   localparam int AW = $clog2(EEP_SIZE);
   localparam int CW = $clog2(WRITE_CYCLES + 1);
   localparam int WW = $clog2(EEMPE_WINDOW + 1);
`ifdef EEP_PROG_TIMING_EN
   localparam logic [CW-1:0] CNT_INIT = CW'(WRITE_CYCLES - 1);
`else
   localparam logic [CW-1:0] CNT_INIT = '0;
`endif

   eep_state_t    r_state;
   logic [7:0]    r_eearh, r_eearl, r_eedr_wr, r_eedr_rd, r_pdata, r_ext_data;
   logic [1:0]    r_eepm;
   logic          r_eepe, r_eerie, r_ack;
   logic [WW-1:0] r_win;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_paddr;

   logic [15:0]   w_eear;
   logic [AW-1:0] w_cpu_addr, w_ram_addr;
   logic [7:0]    w_ram_q, w_ram_wdata;
   logic          w_eecr_wr, w_eempe, w_idle, w_prg_start, w_rd_start;
   logic          w_ext_ok, w_ext_wr, w_ext_rd, w_prg_we, w_ram_we, w_ram_re;
   logic          w_unused;

   assign w_eear      = {r_eearh, r_eearl};
   assign w_cpu_addr  = w_eear[AW-1:0];
   assign w_eecr_wr   = wr_i & (addr_i == EECR_ADDR);
   assign w_eempe     = (r_win != '0);
   assign w_idle      = (r_state == S_IDLE);
   assign w_prg_start = w_eecr_wr & bus_i[EECR_EEPE] & w_eempe & w_idle;
   assign w_rd_start  = w_eecr_wr & bus_i[EECR_EERE] & w_idle & ~w_prg_start;

   // CPU starts take priority; a losing external request is simply dropped.
   assign w_ext_ok = w_idle & ~w_prg_start & ~w_rd_start;
   assign w_ext_wr = w_ext_ok & ext_wr_i;
   assign w_ext_rd = w_ext_ok & ext_rd_i & ~ext_wr_i;

   assign w_prg_we    = (r_state == S_PRG) & (r_cnt == '0) & (r_eepm != EEPM_NONE) & ~rst_i;
   assign w_ram_we    = w_prg_we | (w_ext_wr & ~rst_i);
   assign w_ram_re    = w_rd_start | w_ext_rd | (r_state == S_PRG_RD);
   assign w_ram_addr  = !w_idle ? r_paddr : ((w_ext_wr | w_ext_rd) ? ext_addr_i[AW-1:0] : w_cpu_addr);
   assign w_ram_wdata = w_prg_we ? commit_byte(r_eepm, w_ram_q, r_pdata) : ext_data_i;

   assign int_o              = r_eerie & ~r_eepe;
   assign ext_ack_o          = r_ack;
   assign ext_data_o         = r_ext_data;
   assign content_modified_o = w_ram_we;
   assign w_unused           = &{1'b0, w_eear, ext_addr_i};

   atmega_eep_ram #(
      .PLATFORM (PLATFORM),
      .DEPTH    (EEP_SIZE)
   ) u_ram (
      .i_clk   (clk_i),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_q)
   );

   always_comb begin
      bus_o = 8'h00;
      if (rd_i) begin
         if (addr_i == EEARH_ADDR)      bus_o = r_eearh;
         else if (addr_i == EEARL_ADDR) bus_o = r_eearl;
         else if (addr_i == EEDR_ADDR)  bus_o = r_eedr_rd;
         else if (addr_i == EECR_ADDR)  bus_o = {2'b00, r_eepm, r_eerie, w_eempe, r_eepe, r_state == S_RD};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_eearh    <= '0;
         r_eearl    <= '0;
         r_eedr_wr  <= '0;
         r_eedr_rd  <= '0;
         r_pdata    <= '0;
         r_ext_data <= '0;
         r_eepm     <= '0;
         r_eepe     <= 1'b0;
         r_eerie    <= 1'b0;
         r_ack      <= 1'b0;
         r_win      <= '0;
         r_cnt      <= '0;
         r_paddr    <= '0;
      end else begin
         r_ack <= 1'b0;
         if (wr_i && addr_i == EEARH_ADDR) r_eearh   <= bus_i;
         if (wr_i && addr_i == EEARL_ADDR) r_eearl   <= bus_i;
         if (wr_i && addr_i == EEDR_ADDR)  r_eedr_wr <= bus_i;
         if (w_eecr_wr && bus_i[EECR_EEMPE]) r_win <= WW'(EEMPE_WINDOW);
         else if (w_eempe)                   r_win <= r_win - WW'(1);
         if (w_eecr_wr && !r_eepe) begin
            r_eepm  <= bus_i[5:4];
            r_eerie <= bus_i[EECR_EERIE];
         end
         case (r_state)
            S_IDLE: begin
               if (w_prg_start) begin
                  r_state <= S_PRG_RD;
                  r_eepe  <= 1'b1;
                  r_paddr <= w_cpu_addr;
                  r_pdata <= r_eedr_wr;
                  r_cnt   <= CNT_INIT;
               end else if (w_rd_start) begin
                  r_state <= S_RD;
               end else if (w_ext_wr) begin
                  r_ack <= 1'b1;
               end else if (w_ext_rd) begin
                  r_state <= S_EXT;
               end
            end
            S_RD: begin
               r_eedr_rd <= w_ram_q;
               r_state   <= S_IDLE;
            end
            S_PRG_RD: r_state <= S_PRG;
            S_PRG: begin
               if (r_cnt == '0) begin
                  r_eepe  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_EXT: begin
               r_ext_data <= w_ram_q;
               r_ack      <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_atmega_eep_ctrl.sv
// tb/tb_atmega_eep_ctrl.sv - scoreboard bench for atmega_eep_ctrl
module tb_atmega_eep_ctrl;

   localparam int WC  = 16;
   localparam int WIN = 4;
`ifdef EEP_PROG_TIMING_EN
   localparam int BUSY = WC + 1;
`else
   localparam int BUSY = 2;
`endif
   localparam logic [7:0] A_EEARH = 8'h20;
   localparam logic [7:0] A_EEARL = 8'h21;
   localparam logic [7:0] A_EEDR  = 8'h22;
   localparam logic [7:0] A_EECR  = 8'h23;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  addr_i = '0;
   logic        wr_i = 1'b0;
   logic        rd_i = 1'b0;
   logic [7:0]  bus_i = '0;
   logic [7:0]  bus_o;
   logic        int_o;
   logic [15:0] ext_addr_i = '0;
   logic [7:0]  ext_data_i = '0;
   logic        ext_wr_i = 1'b0;
   logic        ext_rd_i = 1'b0;
   logic [7:0]  ext_data_o;
   logic        ext_ack_o;
   logic        content_modified_o;

   typedef struct { logic [7:0] bus; logic ival; bit use_int; string nm; } rd_exp_t;
   typedef struct { int cyc; logic [7:0] data; bit chk; } ext_exp_t;

   rd_exp_t  q_rd[$];
   ext_exp_t q_ext[$];
   int       q_cm[$];

   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         s_cyc = -100;
   int         l_cyc = -100;
   logic [1:0] tb_eepm = '0;
   logic       tb_eerie = 1'b0;

   atmega_eep_ctrl #(
      .WRITE_CYCLES (WC),
      .EEMPE_WINDOW (WIN)
   ) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .addr_i             (addr_i),
      .wr_i               (wr_i),
      .rd_i               (rd_i),
      .bus_i              (bus_i),
      .bus_o              (bus_o),
      .int_o              (int_o),
      .ext_addr_i         (ext_addr_i),
      .ext_data_i         (ext_data_i),
      .ext_wr_i           (ext_wr_i),
      .ext_rd_i           (ext_rd_i),
      .ext_data_o         (ext_data_o),
      .ext_ack_o          (ext_ack_o),
      .content_modified_o (content_modified_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic void check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void unexpected(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: output asserted with nothing expected (cycle %0d)", nm, cyc);
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents something.
   always @(negedge clk_i) begin
      rd_exp_t  r;
      ext_exp_t x;
      if (rd_i) begin
         if (q_rd.size() == 0) unexpected("rd_unexpected");
         else begin
            r = q_rd.pop_front();
            check(r.nm, bus_o, r.bus);
            if (r.use_int) check({r.nm, "_int"}, int_o, r.ival);
         end
      end
      if (content_modified_o) begin
         if (q_cm.size() == 0) unexpected("content_modified");
         else check("content_modified_cycle", cyc, q_cm.pop_front());
      end
      if (ext_ack_o) begin
         if (q_ext.size() == 0) unexpected("ext_ack");
         else begin
            x = q_ext.pop_front();
            check("ext_ack_cycle", cyc, x.cyc);
            if (x.chk) check("ext_data", ext_data_o, x.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
      addr_i = a; bus_i = d; wr_i = 1'b1;
      tick();
      wr_i = 1'b0; addr_i = '0;
   endtask

   task automatic rd_int(input logic [7:0] a, input logic [7:0] e, input logic ie, input bit ui, input string nm);
      q_rd.push_back('{bus: e, ival: ie, use_int: ui, nm: nm});
      addr_i = a; rd_i = 1'b1;
      tick();
      rd_i = 1'b0; addr_i = '0;
   endtask

   function automatic logic [7:0] exp_eecr(input int t);
      logic pe, mpe;
      pe  = (t > s_cyc) && (t <= s_cyc + BUSY);
      mpe = (t > l_cyc) && (t <= l_cyc + WIN);
      return {2'b00, tb_eepm, tb_eerie, mpe, pe, 1'b0};
   endfunction

   task automatic prog(input logic [15:0] a, input logic [7:0] d, input logic [1:0] pm,
                       input logic ie, input bit tie);
      logic [7:0] e;
      wr_reg(A_EEARH, a[15:8]);
      wr_reg(A_EEARL, a[7:0]);
      wr_reg(A_EEDR, d);
      tb_eepm = pm; tb_eerie = ie;
      l_cyc = cyc;
      wr_reg(A_EECR, {2'b00, pm, ie, 3'b100});
      s_cyc = cyc;
      if (pm != 2'b11) q_cm.push_back(s_cyc + BUSY);
      if (tie) begin
         ext_addr_i = 16'h03FF; ext_data_i = 8'hA5; ext_wr_i = 1'b1;
      end
      wr_reg(A_EECR, {2'b00, pm, ie, 3'b010});
      ext_wr_i = 1'b0;
      for (int i = 0; i <= BUSY; i++) begin
         e = exp_eecr(cyc);
         rd_int(A_EECR, e, ie & ~e[1], 1'b1, "eecr_prog");
      end
   endtask

   task automatic do_read(input logic [15:0] a, input logic [7:0] d, input string nm);
      wr_reg(A_EEARH, a[15:8]);
      wr_reg(A_EEARL, a[7:0]);
      wr_reg(A_EECR, 8'h01);
      tb_eepm = '0; tb_eerie = 1'b0;
      rd_int(A_EECR, 8'h01, 1'b0, 1'b0, "eere_busy");
      rd_int(A_EEDR, d, 1'b0, 1'b0, nm);
   endtask

   task automatic ext_write(input logic [15:0] a, input logic [7:0] d);
      q_cm.push_back(cyc);
      q_ext.push_back('{cyc: cyc + 1, data: 8'h00, chk: 1'b0});
      ext_addr_i = a; ext_data_i = d; ext_wr_i = 1'b1;
      tick();
      ext_wr_i = 1'b0;
   endtask

   task automatic ext_read(input logic [15:0] a, input logic [7:0] d);
      q_ext.push_back('{cyc: cyc + 2, data: d, chk: 1'b1});
      ext_addr_i = a; ext_rd_i = 1'b1;
      tick();
      ext_rd_i = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      rst_i = 1'b0;
      rd_int(A_EECR, 8'h00, 1'b0, 1'b1, "reset_eecr");
      rd_int(A_EEDR, 8'h00, 1'b0, 1'b0, "reset_eedr");
      rd_int(A_EEARH, 8'h00, 1'b0, 1'b0, "reset_eearh");
      rd_int(A_EEARL, 8'h00, 1'b0, 1'b0, "reset_eearl");
      rd_int(8'h10, 8'h00, 1'b0, 1'b0, "no_hit_zero");

      prog(16'h0012, 8'h5A, 2'b00, 1'b0, 1'b0);
      do_read(16'h0012, 8'h5A, "rd_erase_write");

      // EEMPE window has lapsed by the time EEPE is written.
      wr_reg(A_EECR, 8'h04);
      repeat (5) tick();
      wr_reg(A_EECR, 8'h02);
      rd_int(A_EECR, 8'h00, 1'b0, 1'b1, "eepe_rejected");
      do_read(16'h0020, 8'hFF, "rd_erased");

      prog(16'h0030, 8'hF0, 2'b00, 1'b0, 1'b0);
      prog(16'h0030, 8'h3C, 2'b10, 1'b0, 1'b0);
      do_read(16'h0030, 8'h30, "rd_write_only");
      prog(16'h0030, 8'h00, 2'b01, 1'b0, 1'b0);
      do_read(16'h0030, 8'hFF, "rd_erase_only");
      prog(16'h0030, 8'h12, 2'b11, 1'b0, 1'b0);
      do_read(16'h0030, 8'hFF, "rd_no_write");

      prog(16'h0040, 8'h77, 2'b00, 1'b1, 1'b0);
      rd_int(A_EECR, 8'h08, 1'b1, 1'b1, "eerie_idle");

      // External write loses to the CPU start in the same cycle, then retries.
      prog(16'h0050, 8'h66, 2'b00, 1'b0, 1'b1);
      ext_write(16'h03FF, 8'hA5);
      tick();
      ext_read(16'h03FF, 8'hA5);
      repeat (2) tick();
      wr_reg(A_EEARH, 8'h07);
      rd_int(A_EEARH, 8'h07, 1'b0, 1'b0, "eearh_full");
      do_read(16'h07FF, 8'hA5, "rd_alias");
      do_read(16'h0050, 8'h66, "rd_tie_cpu");

      // Reset lands while PRG is active.
      wr_reg(A_EEARH, 8'h00);
      wr_reg(A_EEARL, 8'h60);
      wr_reg(A_EEDR, 8'h11);
      wr_reg(A_EECR, 8'h0C);
      wr_reg(A_EECR, 8'h0A);
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      rd_int(A_EECR, 8'h00, 1'b0, 1'b1, "abort_eecr");
      do_read(16'h0060, 8'hFF, "rd_aborted");

      repeat (4) tick();
      check("cm_queue_left", q_cm.size(), 0);
      check("ext_queue_left", q_ext.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
